// File: rtl/ring_mac_pe.sv
// Ring multiply-accumulate element: forwards samples downstream and replaces
// the last sample of every N-sample frame with the accumulated dot product.
module ring_mac_pe #(
    parameter int unsigned DW  = 16,
    parameter int unsigned N   = 4,
    parameter bit          SAT = 1'b0,
    parameter int unsigned AW  = 2 * DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [DW-1:0] x_init,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] a,
    input  logic          in_valid,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic          done,
    output logic          sat_flag
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * DW;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic signed [AW-1:0] MAX_V = AW'({1'b0, {(DW - 1){1'b1}}});
    localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        cnt;
    logic                 hi_clip;
    logic                 lo_clip;
    logic [DW-1:0]        result;

    assign prod = $signed(x) * $signed(a);
    assign sum  = acc + AW'(prod);

    // Frame result: plain truncation, or clamp to the signed DW range.
    always_comb begin
        hi_clip = 1'b0;
        lo_clip = 1'b0;
        result  = sum[DW-1:0];
        if (SAT) begin
            hi_clip = (sum > MAX_V);
            lo_clip = (sum < MIN_V);
            if (hi_clip) begin
                result = MAX_V[DW-1:0];
            end else if (lo_clip) begin
                result = MIN_V[DW-1:0];
            end
        end
    end

    // init takes priority over a sample arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y        <= '0;
            y_valid  <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else if (init) begin
            y        <= x_init;
            y_valid  <= 1'b1;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else if (in_valid) begin
            y_valid <= 1'b1;
            if (cnt == LAST) begin
                y    <= result;
                done <= 1'b1;
                acc  <= '0;
                cnt  <= '0;
                if (hi_clip || lo_clip) begin
                    sat_flag <= 1'b1;
                end
            end else begin
                y    <= x;
                done <= 1'b0;
                acc  <= sum;
                cnt  <= cnt + CW'(1);
            end
        end else begin
            y_valid <= 1'b0;
            done    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_mac_pe.sv
// Directed bench for ring_mac_pe: a wrapping and a saturating instance share
// the same stimulus; expected values are hand-computed for N=4, DW=16.
module tb_ring_mac_pe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0;
    logic [15:0] x_init = '0;
    logic [15:0] x = '0;
    logic [15:0] a = '0;
    logic        in_valid = 1'b0;

    logic [15:0] y_w, y_s;
    logic        yv_w, yv_s, done_w, done_s, sf_w, sf_s;

    int checks = 0;
    int errors = 0;

    ring_mac_pe #(.DW(16), .N(4), .SAT(1'b0)) dut (
        .clk(clk), .reset(reset), .init(init), .x_init(x_init), .x(x), .a(a),
        .in_valid(in_valid), .y(y_w), .y_valid(yv_w), .done(done_w), .sat_flag(sf_w)
    );

    ring_mac_pe #(.DW(16), .N(4), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .init(init), .x_init(x_init), .x(x), .a(a),
        .in_valid(in_valid), .y(y_s), .y_valid(yv_s), .done(done_s), .sat_flag(sf_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            init     = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            x        = 16'($urandom);
            a        = 16'($urandom);
            x_init   = 16'($urandom);
            tick();
            checks++;
            if ({y_w, yv_w, done_w, sf_w} !== 19'h0) begin
                errors++;
                $display("FAIL reset_wrap cyc%0d: y=%h yv=%b done=%b sf=%b required 0", i, y_w, yv_w, done_w, sf_w);
            end
            checks++;
            if ({y_s, yv_s, done_s, sf_s} !== 19'h0) begin
                errors++;
                $display("FAIL reset_sat cyc%0d: y=%h yv=%b done=%b sf=%b required 0", i, y_s, yv_s, done_s, sf_s);
            end
        end
        init = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_preload();
        init = 1'b1; x_init = 16'h0005; in_valid = 1'b1; x = 16'h0009; a = 16'h0001;
        tick();
        init = 1'b0; in_valid = 1'b0;
        checks++;
        if (y_w !== 16'h0005 || yv_w !== 1'b1 || done_w !== 1'b0) begin
            errors++;
            $display("FAIL preload: y=%h yv=%b done=%b required y=0005 yv=1 done=0", y_w, yv_w, done_w);
        end
        tick();
        checks++;
        if (y_w !== 16'h0005 || yv_w !== 1'b0 || done_w !== 1'b0) begin
            errors++;
            $display("FAIL preload_hold: y=%h yv=%b done=%b required y=0005 yv=0 done=0", y_w, yv_w, done_w);
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] av,
                             input logic [15:0] xs [4], input logic [15:0] ys [4],
                             input bit bubbles);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = av; x = xs[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (y_w !== ys[i] || yv_w !== 1'b1 || done_w !== (i == 3)) begin
                errors++;
                $display("FAIL %s s%0d: y=%h yv=%b done=%b required y=%h yv=1 done=%b",
                         name, i, y_w, yv_w, done_w, ys[i], (i == 3));
            end
            if (bubbles) begin
                x = 16'($urandom); a = 16'($urandom);
                tick();
                checks++;
                if (y_w !== ys[i] || yv_w !== 1'b0 || done_w !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bubble%0d: y=%h yv=%b done=%b required y=%h yv=0 done=0",
                             name, i, y_w, yv_w, done_w, ys[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame("frame_a2", 16'h0002, '{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd1, 16'd2, 16'd3, 16'd20}, 1'b0);
        run_frame("frame_neg", 16'hFFFF, '{16'd3, 16'd3, 16'd3, 16'd3}, '{16'd3, 16'd3, 16'd3, 16'hFFF4}, 1'b0);
        checks++;
        if (y_s !== 16'hFFF4 || sf_s !== 1'b0) begin
            errors++;
            $display("FAIL frame_neg_sat: y=%h sf=%b required y=fff4 sf=0", y_s, sf_s);
        end
    endtask

    task automatic test_bubbles();
        run_frame("bub_a2", 16'h0002, '{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd1, 16'd2, 16'd3, 16'd20}, 1'b1);
        run_frame("bub_neg", 16'hFFFF, '{16'd3, 16'd3, 16'd3, 16'd3}, '{16'd3, 16'd3, 16'd3, 16'hFFF4}, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 16'h7FFF; x = 16'h7FFF;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (y_w !== 16'h0004 || done_w !== 1'b1 || sf_w !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wrap: y=%h done=%b sf=%b required y=0004 done=1 sf=0", y_w, done_w, sf_w);
        end
        checks++;
        if (y_s !== 16'h7FFF || done_s !== 1'b1 || sf_s !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat: y=%h done=%b sf=%b required y=7fff done=1 sf=1", y_s, done_s, sf_s);
        end
        tick();
        checks++;
        if (sf_s !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: sf=%b required 1", sf_s);
        end
        init = 1'b1; x_init = 16'h0000;
        tick();
        init = 1'b0;
        checks++;
        if (sf_s !== 1'b0 || y_s !== 16'h0000 || yv_s !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: sf=%b y=%h yv=%b required sf=0 y=0000 yv=1", sf_s, y_s, yv_s);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 16'd3; x = 16'd5;
            tick();
            checks++;
            if (y_w !== 16'd5 || done_w !== 1'b0) begin
                errors++;
                $display("FAIL restart_pre%0d: y=%h done=%b required y=0005 done=0", i, y_w, done_w);
            end
        end
        init = 1'b1; in_valid = 1'b1; x_init = 16'h0009; x = 16'd7;
        tick();
        init = 1'b0;
        checks++;
        if (y_w !== 16'h0009 || yv_w !== 1'b1 || done_w !== 1'b0) begin
            errors++;
            $display("FAIL restart_init: y=%h yv=%b done=%b required y=0009 yv=1 done=0", y_w, yv_w, done_w);
        end
        run_frame("restart", 16'd1, '{16'd1, 16'd1, 16'd1, 16'd1}, '{16'd1, 16'd1, 16'd1, 16'd4}, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 16'd7; x = 16'd9;
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({y_w, yv_w, done_w, sf_w} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: y=%h yv=%b done=%b sf=%b required 0", y_w, yv_w, done_w, sf_w);
        end
        tick();
        reset = 1'b1;
        run_frame("post_reset", 16'h0002, '{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd1, 16'd2, 16'd3, 16'd20}, 1'b0);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_back_to_back();
        test_bubbles();
        test_overflow();
        test_restart();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
